instruction_issue: RTL and testbench

Issue stage (IX) between instruction decode and the execution pipes. Accepts one decoded instruction per cycle and reads both source operands from a 32x32 register file. Holds the instruction until its operands are free of pending writes and its target pipe is ready, then issues it. It also owns the register file write port and the scoreboard, which the retire/writeback path updates.

---
 rtl/instruction_issue.sv | 130 +++++++++++++
 tb/tb_instruction_issue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issue.sv
// Issue stage: holds one decoded instruction until its operands and target pipe are free,
// then registers it with its operand values. Also owns the register file and the scoreboard.
package instruction_issue_pkg;
    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 32;

    localparam int EXE_PIPE_ID_ALU = 0;
    localparam int EXE_PIPE_ID_MUL = 1;
    localparam int EXE_PIPE_ID_DIV = 2;
    localparam int EXE_PIPE_ID_LSU = 3;

    typedef logic [3:0] exe_pipe_e;

    typedef struct packed {
        logic [REG_WIDTH-1:0]  a1;
        logic [REG_WIDTH-1:0]  a2;
        logic [REG_WIDTH-1:0]  rd;
        logic                  register_write;
        exe_pipe_e             exe_pipe;
        logic [3:0]            op;
        logic [DATA_WIDTH-1:0] imm;
    } id_ix_inf_t;
endpackage

module instruction_issue
    import instruction_issue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_do_branch,
    input  logic                  id_valid,
    input  id_ix_inf_t            id_ix_inf,
    output logic                  ix_stall,
    input  logic [3:0]            exe_ready,
    input  logic                  wb_retire_valid,
    input  logic [REG_WIDTH-1:0]  wb_retire_rd,
    input  logic                  wb_retire_write,
    input  logic [DATA_WIDTH-1:0] wb_retire_data,
    output logic                  ix_valid,
    output id_ix_inf_t            ix_inf,
    output logic [DATA_WIDTH-1:0] ix_rs1_data,
    output logic [DATA_WIDTH-1:0] ix_rs2_data
);
    logic [DATA_WIDTH-1:0] r_regfile [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pending;
    logic                  r_ix_valid;
    id_ix_inf_t            r_ix_inf;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;

    logic                  w_rf_we;
    logic [NUM_REGS-1:0]   w_retire_mask;
    logic [NUM_REGS-1:0]   w_pending_eff;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_pending_next;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;
    logic                  w_hazard;
    logic                  w_pipe_ok;
    logic                  w_consider;
    logic                  w_issue;

    assign w_rf_we       = wb_retire_valid & wb_retire_write & (wb_retire_rd != '0);
    assign w_retire_mask = wb_retire_valid ? (NUM_REGS'(1) << wb_retire_rd) : '0;
    // A retiring register is free this cycle: its value arrives through the read bypass.
    assign w_pending_eff = r_pending & ~w_retire_mask;

    assign w_rs1_data = (id_ix_inf.a1 == '0)                    ? '0 :
                        (w_rf_we && wb_retire_rd == id_ix_inf.a1) ? wb_retire_data :
                                                                    r_regfile[id_ix_inf.a1];
    assign w_rs2_data = (id_ix_inf.a2 == '0)                    ? '0 :
                        (w_rf_we && wb_retire_rd == id_ix_inf.a2) ? wb_retire_data :
                                                                    r_regfile[id_ix_inf.a2];

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_hazard   = 1'b0;
        w_pipe_ok  = |(id_ix_inf.exe_pipe & exe_ready);
        w_consider = id_valid & ~wb_do_branch & (id_ix_inf.exe_pipe != '0);
        w_set_mask = '0;

        if (id_ix_inf.a1 != '0 && w_pending_eff[id_ix_inf.a1])
            w_hazard = 1'b1;
        if (id_ix_inf.a2 != '0 && w_pending_eff[id_ix_inf.a2])
            w_hazard = 1'b1;
        if (id_ix_inf.register_write && w_pending_eff[id_ix_inf.rd])
            w_hazard = 1'b1;

        w_issue  = w_consider & ~w_hazard & w_pipe_ok;
        ix_stall = w_consider & (w_hazard | ~w_pipe_ok);

        if (w_issue && id_ix_inf.register_write && id_ix_inf.rd != '0)
            w_set_mask = NUM_REGS'(1) << id_ix_inf.rd;

        // Set is applied after clear so an issue and a retire on the same register leave it pending.
        w_pending_next    = (r_pending & ~w_retire_mask) | w_set_mask;
        w_pending_next[0] = 1'b0;
    end

    // NOTE: the register array has no reset; only control state is cleared, x0 is forced by the read mux.
    always_ff @(posedge clk) begin
        if (w_rf_we)
            r_regfile[wb_retire_rd] <= wb_retire_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_ix_valid <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_ix_valid <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_issue) begin
            r_ix_inf   <= id_ix_inf;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
        end
    end

    assign ix_valid    = r_ix_valid;
    assign ix_inf      = r_ix_inf;
    assign ix_rs1_data = r_rs1_data;
    assign ix_rs2_data = r_rs2_data;
endmodule

// File: tb/tb_instruction_issue.sv
// Randomized and directed bench for instruction_issue against a cycle-level reference model
// built from the issue rules (register array, pending flags, expected issue slot).
module tb_instruction_issue;
    import instruction_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_do_branch;
    logic        id_valid;
    id_ix_inf_t  id_ix_inf;
    logic        ix_stall;
    logic [3:0]  exe_ready;
    logic        wb_retire_valid;
    logic [4:0]  wb_retire_rd;
    logic        wb_retire_write;
    logic [31:0] wb_retire_data;
    logic        ix_valid;
    id_ix_inf_t  ix_inf;
    logic [31:0] ix_rs1_data;
    logic [31:0] ix_rs2_data;

    always #5 clk = ~clk;

    instruction_issue dut (
        .clk             (clk),
        .rst             (rst),
        .wb_do_branch    (wb_do_branch),
        .id_valid        (id_valid),
        .id_ix_inf       (id_ix_inf),
        .ix_stall        (ix_stall),
        .exe_ready       (exe_ready),
        .wb_retire_valid (wb_retire_valid),
        .wb_retire_rd    (wb_retire_rd),
        .wb_retire_write (wb_retire_write),
        .wb_retire_data  (wb_retire_data),
        .ix_valid        (ix_valid),
        .ix_inf          (ix_inf),
        .ix_rs1_data     (ix_rs1_data),
        .ix_rs2_data     (ix_rs2_data)
    );

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          exp_valid;
    id_ix_inf_t  exp_inf;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    bit          m_stall;
    int          n_stall_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int r);
        return r != 0 && m_pend[r] && !(wb_retire_valid && int'(wb_retire_rd) == r);
    endfunction

    function automatic logic [31:0] m_read(input int r);
        if (r == 0) return 32'h0;
        if (wb_retire_valid && wb_retire_write && int'(wb_retire_rd) == r) return wb_retire_data;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock: check outputs mid-cycle, then advance the model across the rising edge.
    task automatic step();
        bit consider, hz, ok, issue;
        @(negedge clk);
        check("ix_valid", 64'(ix_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("ix_inf", 64'(ix_inf), 64'(exp_inf));
            check("ix_rs1_data", 64'(ix_rs1_data), 64'(exp_rs1));
            check("ix_rs2_data", 64'(ix_rs2_data), 64'(exp_rs2));
        end
        check("pending", 64'(dut.r_pending), 64'(m_pend_vec()));
        consider = id_valid && !wb_do_branch && id_ix_inf.exe_pipe != 4'h0;
        hz = m_busy(int'(id_ix_inf.a1)) || m_busy(int'(id_ix_inf.a2)) ||
             (id_ix_inf.register_write && m_busy(int'(id_ix_inf.rd)));
        ok = (id_ix_inf.exe_pipe & exe_ready) != 4'h0;
        issue   = consider && !hz && ok;
        m_stall = consider && (hz || !ok);
        check("ix_stall", 64'(ix_stall), 64'(m_stall));
        if (ix_stall === 1'b1) n_stall_seen++;
        @(posedge clk);
        if (rst) begin
            exp_valid = 1'b0;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            exp_valid = issue;
            if (issue) begin
                exp_inf = id_ix_inf;
                exp_rs1 = m_read(int'(id_ix_inf.a1));
                exp_rs2 = m_read(int'(id_ix_inf.a2));
            end
            if (wb_retire_valid) m_pend[wb_retire_rd] = 1'b0;
            if (issue && id_ix_inf.register_write && id_ix_inf.rd != 5'd0) m_pend[id_ix_inf.rd] = 1'b1;
        end
        if (wb_retire_valid && wb_retire_write && wb_retire_rd != 5'd0) m_regs[wb_retire_rd] = wb_retire_data;
        #1;
    endtask

    task automatic drive_id(input bit v, input int a1, input int a2, input int rd, input bit rw, input int pipe_id);
        id_ix_inf_t inf;
        inf.a1             = 5'(a1);
        inf.a2             = 5'(a2);
        inf.rd             = 5'(rd);
        inf.register_write = rw;
        inf.exe_pipe       = (pipe_id < 0) ? 4'h0 : 4'(1 << pipe_id);
        inf.op             = 4'($urandom);
        inf.imm            = $urandom;
        id_valid  = v;
        id_ix_inf = inf;
    endtask

    task automatic drive_ret(input bit v, input int rd, input bit w, input logic [31:0] d);
        wb_retire_valid = v;
        wb_retire_rd    = 5'(rd);
        wb_retire_write = w;
        wb_retire_data  = d;
    endtask

    initial begin
        int q[$];
        int r;
        int pid;

        rst = 1'b1;
        wb_do_branch = 1'b0;
        exe_ready = 4'hF;
        drive_id(1'b0, 0, 0, 0, 1'b0, -1);
        drive_ret(1'b0, 0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;

        // Load every register; x0 receives all ones and must still read as zero.
        for (int i = 0; i < 32; i++) begin
            drive_ret(1'b1, i, 1'b1, (i == 0) ? 32'hFFFF_FFFF : $urandom);
            step();
        end
        drive_ret(1'b0, 0, 1'b0, 32'h0);

        // Independent back-to-back stream.
        n_stall_seen = 0;
        drive_id(1'b1, 0, 0, 1, 1'b1, EXE_PIPE_ID_ALU); step();
        drive_id(1'b1, 3, 0, 2, 1'b1, EXE_PIPE_ID_ALU); step();
        drive_id(1'b0, 0, 0, 0, 1'b0, -1);              step();
        check("indep_stalls", 64'(n_stall_seen), 64'd0);
        check("indep_pend12", 64'(dut.r_pending[2:1]), 64'd3);

        // RAW on x5 resolved by a bypassed retire.
        drive_id(1'b1, 3, 4, 5, 1'b1, EXE_PIPE_ID_MUL); step();
        drive_id(1'b1, 5, 0, 6, 1'b1, EXE_PIPE_ID_ALU);
        n_stall_seen = 0;
        repeat (3) step();
        drive_ret(1'b1, 5, 1'b1, 32'h1234); step();
        check("raw_stalls", 64'(n_stall_seen), 64'd3);
        drive_ret(1'b0, 0, 1'b0, 32'h0);
        drive_id(1'b0, 0, 0, 0, 1'b0, -1); step();
        check("raw_bypass", 64'(ix_rs1_data), 64'h1234);

        // WAW on x7 with set and clear landing in the same cycle.
        drive_id(1'b1, 0, 0, 7, 1'b1, EXE_PIPE_ID_LSU); step();
        drive_id(1'b1, 0, 0, 7, 1'b1, EXE_PIPE_ID_ALU);
        n_stall_seen = 0;
        repeat (2) step();
        drive_ret(1'b1, 7, 1'b1, $urandom); step();
        check("waw_stalls", 64'(n_stall_seen), 64'd2);
        check("waw_pend7", 64'(dut.r_pending[7]), 64'd1);
        drive_ret(1'b0, 0, 1'b0, 32'h0);
        drive_id(1'b0, 0, 0, 0, 1'b0, -1); step();

        // Divider busy for four cycles.
        exe_ready = 4'b1011;
        drive_id(1'b1, 3, 4, 8, 1'b1, EXE_PIPE_ID_DIV);
        n_stall_seen = 0;
        repeat (4) step();
        exe_ready = 4'hF; step();
        check("div_stalls", 64'(n_stall_seen), 64'd4);
        drive_id(1'b0, 0, 0, 0, 1'b0, -1); step();

        // Flush of a stalled instruction: no issue, scoreboard kept.
        drive_id(1'b1, 8, 0, 9, 1'b1, EXE_PIPE_ID_ALU); step();
        wb_do_branch = 1'b1; step();
        wb_do_branch = 1'b0;
        drive_id(1'b0, 0, 0, 0, 1'b0, -1); step();
        check("flush_pend8", 64'(dut.r_pending[9:8]), 64'd1);

        // Unimplemented opcode with pending operands is swallowed without a stall.
        drive_id(1'b1, 8, 8, 0, 1'b0, -1); step();

        // x0 write attempts, same-cycle and earlier, never leak into reads.
        drive_ret(1'b1, 0, 1'b1, 32'hFFFF_FFFF);
        drive_id(1'b1, 0, 0, 10, 1'b1, EXE_PIPE_ID_ALU); step();
        drive_ret(1'b0, 0, 1'b0, 32'h0);
        drive_id(1'b1, 0, 0, 11, 1'b1, EXE_PIPE_ID_ALU); step();
        drive_id(1'b0, 0, 0, 0, 1'b0, -1); step();
        check("x0_read", 64'(ix_rs1_data), 64'd0);

        // Reset while an instruction is held.
        drive_id(1'b1, 8, 0, 13, 1'b1, EXE_PIPE_ID_ALU); step();
        rst = 1'b1;
        drive_id(1'b0, 0, 0, 0, 1'b0, -1); step();
        rst = 1'b0; step();
        check("rst_pending", 64'(dut.r_pending), 64'd0);

        // Random traffic with a protocol-respecting upstream.
        m_stall = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!m_stall) begin
                if ($urandom_range(9) < 7) begin
                    pid = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(3));
                    drive_id(1'b1, int'($urandom_range(15)), int'($urandom_range(15)),
                             int'($urandom_range(15)), 1'($urandom_range(1)), pid);
                end else begin
                    drive_id(1'b0, 0, 0, 0, 1'b0, -1);
                end
            end
            exe_ready    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            wb_do_branch = ($urandom_range(19) == 0);
            if ($urandom_range(9) < 4) begin
                q.delete();
                for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
                if (q.size() > 0 && $urandom_range(4) != 0) r = q[$urandom_range(q.size() - 1)];
                else r = int'($urandom_range(31));
                drive_ret(1'b1, r, ($urandom_range(9) < 7), $urandom);
            end else begin
                drive_ret(1'b0, 0, 1'b0, 32'h0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
